uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  UART receiver: partner to the TX serializer/output-mux path. Oversamples RX_IN,
//  detects start, shifts DATA_WIDTH bits LSB-first, checks optional parity and stop bit.
//  Presents a parallel word with a 1-cycle DATA_VALID strobe to the system side.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame
//  PRESC_W     6  width of PRESCALE and the oversample edge counter
// PORTS
//  CLK         in   1           oversample clock (PRESCALE ticks per bit)
//  RST         in   1           asynchronous, active-low reset
//  RX_IN       in   1           serial line, idle high, async to CLK
//  PRESCALE    in   PRESC_W     oversample ratio; legal 8, 16, 32
//  PAR_EN      in   1           1 = parity bit present after data
//  PAR_TYP     in   1           0 = even, 1 = odd
//  P_DATA      out  DATA_WIDTH  last good word; held until the next good frame
//  DATA_VALID  out  1           1-cycle strobe, P_DATA updated the same cycle
//  PAR_ERR     out  1           1-cycle strobe, parity mismatch
//  STP_ERR     out  1           1-cycle strobe, stop bit sampled 0
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE, counters 0, sync flops=1, all outputs 0.
//  - RX_IN passes a 2-flop synchronizer (reset 1); rx_s = 2nd-flop output.
//  - PRESCALE, PAR_EN, PAR_TYP captured at start detect; mid-frame changes are ignored.
//  - edge_cnt: 0..PRESCALE-1 within each bit; bit_cnt counts bits in the current state.
//  - Sample point: edge_cnt == PRESCALE/2. The bit value is latched there.
//  - FSM:
//     IDLE   : falling edge of rx_s (prev 1, now 0) -> START. That cycle counts as edge_cnt=0.
//              A line held low (break) never re-arms until rx_s returns to 1.
//     START  : sample 1 -> false start; go to IDLE at once, no strobes. Sample 0 -> DATA
//              after edge_cnt == PRESCALE-1.
//     DATA   : shift sample into shift register LSB-first. After DATA_WIDTH bits -> PARITY
//              if PAR_EN, else STOP.
//     PARITY : expected = ^data ^ PAR_TYP. Mismatch sets the internal par_fail flag.
//     STOP   : at edge_cnt == PRESCALE-1 go to IDLE and register the result:
//              no error -> P_DATA <= shift, DATA_VALID=1;
//              par_fail -> PAR_ERR=1; stop sample 0 -> STP_ERR=1 (both may pulse together);
//              any error -> DATA_VALID=0 and P_DATA unchanged.
//  - Latency: strobes are high for exactly the 1 cycle at N*PRESCALE+2 CLK edges after the
//    first edge sampling RX_IN=0 at the pin. N = 1+DATA_WIDTH+PAR_EN+1.
//  - Back-to-back frames: the IDLE cycle after STOP detects the next start with no gap
//    required. Tolerance is +/- PRESCALE/2-1 ticks of drift per frame.
//  - PRESCALE outside {8,16,32}: behaviour undefined, but the FSM always returns to IDLE.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each bit is sampled at PRESCALE/2-1, /2 and /2+1, takes the
//    2-of-3 majority, and the decision is made at PRESCALE/2+1. A 1-tick glitch never
//    corrupts a bit or causes a false start.
//  Not defined: single sample at PRESCALE/2, no extra flops; a glitch on the sample tick
//    is taken as the bit value.
// TESTING
//  1 PRESCALE=8, PAR_EN=0, send 0xA5 with stop=1 -> DATA_VALID 1 cycle at edge 82,
//    P_DATA=0xA5, no errors.
//  2 PRESCALE=16, PAR_EN=1, PAR_TYP=0, 0xA5 with parity bit 1 -> PAR_ERR 1 cycle,
//    DATA_VALID=0, P_DATA keeps the prior value. Then parity 0 -> P_DATA=0xA5.
//  3 PRESCALE=8, 0x3C with stop bit 0 -> STP_ERR 1 cycle. The line then held low 200 cycles
//    -> no further strobes. Release, send 0x11 -> P_DATA=0x11.
//  4 PRESCALE=16, RX_IN low for 3 cycles then high -> false start, FSM back in IDLE,
//    no strobes.
//  5 PRESCALE=32, PAR_EN=1, PAR_TYP=1, 0x3C then 0xC3 back-to-back -> two DATA_VALID
//    pulses 352 cycles apart, correct data. RST pulsed during data bit 4 of a third
//    frame -> outputs 0 at once, and the next 0x55 is received correctly.
//  6 UART_RX_MAJORITY_EN, PRESCALE=8: 1-cycle inverted glitch on the mid tick of data
//    bit 2 of 0xF0 -> P_DATA=0xF0. Without the macro -> P_DATA=0xF4.

Source files
------------

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampled UART frame receiver; define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic                  sync1_q;
  logic                  rx_s_q;

  state_t                state_q;
  logic [PRESC_W-1:0]    edge_cnt_q;
  logic [PRESC_W-1:0]    presc_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_fail_q;
  logic                  stop_bit_q;
  logic                  armed_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  logic [PRESC_W-1:0]    half_d;
  logic                  last_tick_d;
  logic                  samp_tick_d;
  logic                  samp_bit_d;
  logic                  par_exp_d;

  // Two-flop synchronizer; idles high so reset looks like an idle line
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      rx_s_q  <= sync1_q;
    end
  end

  assign half_d      = presc_q >> 1;
  assign last_tick_d = (edge_cnt_q == presc_q - PRESC_W'(1));
  assign par_exp_d   = (^shift_q) ^ par_typ_q;

`ifdef UART_RX_MAJORITY_EN
  logic maj_a_q;
  logic maj_b_q;

  // Capture the two early votes that precede the decision tick
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      maj_a_q <= 1'b0;
      maj_b_q <= 1'b0;
    end else begin
      if (edge_cnt_q == half_d - PRESC_W'(1)) maj_a_q <= rx_s_q;
      if (edge_cnt_q == half_d)               maj_b_q <= rx_s_q;
    end
  end

  assign samp_tick_d = (edge_cnt_q == half_d + PRESC_W'(1));
  assign samp_bit_d  = (maj_a_q & maj_b_q) | (maj_a_q & rx_s_q) | (maj_b_q & rx_s_q);
`else
  assign samp_tick_d = (edge_cnt_q == half_d);
  assign samp_bit_d  = rx_s_q;
`endif

  // Frame FSM: start detect, bit timing, shifting, checks and registered result strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      presc_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_fail_q   <= 1'b0;
      stop_bit_q   <= 1'b0;
      armed_q      <= 1'b1;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;

      // Only a high line seen outside the payload re-arms start detection,
      // so a held-low break cannot retrigger a frame.
      if (rx_s_q && (state_q == IDLE || state_q == STOP)) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (armed_q && !rx_s_q) begin
            // The detect cycle is tick 0 of the start bit
            state_q    <= START;
            edge_cnt_q <= PRESC_W'(1);
            presc_q    <= PRESCALE;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            par_fail_q <= 1'b0;
            armed_q    <= 1'b0;
          end else begin
            edge_cnt_q <= '0;
          end
        end

        START: begin
          edge_cnt_q <= edge_cnt_q + PRESC_W'(1);
          if (samp_tick_d && samp_bit_d) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
          end else if (last_tick_d) begin
            state_q    <= DATA;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        end

        DATA: begin
          edge_cnt_q <= edge_cnt_q + PRESC_W'(1);
          if (samp_tick_d) shift_q <= {samp_bit_d, shift_q[DATA_WIDTH-1:1]};
          if (last_tick_d) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          edge_cnt_q <= edge_cnt_q + PRESC_W'(1);
          if (samp_tick_d) par_fail_q <= (samp_bit_d != par_exp_d);
          if (last_tick_d) begin
            edge_cnt_q <= '0;
            state_q    <= STOP;
          end
        end

        STOP: begin
          edge_cnt_q <= edge_cnt_q + PRESC_W'(1);
          if (samp_tick_d) stop_bit_q <= samp_bit_d;
          if (last_tick_d) begin
            edge_cnt_q <= '0;
            state_q    <= IDLE;
            par_fail_q <= 1'b0;
            if (!par_fail_q && stop_bit_q) begin
              p_data_q     <= shift_q;
              data_valid_q <= 1'b1;
            end else begin
              par_err_q <= par_fail_q;
              stp_err_q <= !stop_bit_q;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          edge_cnt_q <= '0;
        end
      endcase
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame
module tb_uart_rx_frame;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] PRESCALE = PW'(8);
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;

  uart_rx_frame #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int            edge_n;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] pd;
  } ev_t;

  ev_t evq[$];

  // Record every strobe with the number of the posedge that will see it high
  always @(negedge CLK) begin
    if (DATA_VALID || PAR_ERR || STP_ERR)
      evq.push_back('{cyc + 1, DATA_VALID, PAR_ERR, STP_ERR, P_DATA});
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] model_pd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic par_bit(input logic [DW-1:0] d, input logic ptyp, input logic bad);
    return logic'($countones(d) % 2) ^ ptyp ^ bad;
  endfunction

  // Caller must be at a negedge; returns at the negedge after the last bit
  task automatic send_frame(input logic [DW-1:0] d, input int presc, input logic pen,
                            input logic ptyp, input logic bad_par, input logic stop_val,
                            input int glitch_idx, input logic idle_val, output int t0);
    logic bits[$];
    PRESCALE = PW'(presc);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(par_bit(d, ptyp, bad_par));
    bits.push_back(stop_val);
    t0 = 0;
    for (int i = 0; i < bits.size(); i++) begin
      RX_IN = bits[i];
      if (i == 0) t0 = cyc + 1;
      if (i == glitch_idx) begin
        repeat (presc / 2) @(negedge CLK);
        RX_IN = ~bits[i];
        @(negedge CLK);
        RX_IN = bits[i];
        repeat (presc / 2 - 1) @(negedge CLK);
      end else begin
        repeat (presc) @(negedge CLK);
      end
    end
    RX_IN = idle_val;
  endtask

  task automatic check_event(input string name, input int t0, input int nbits, input int presc,
                             input logic dv, input logic pe, input logic se, input logic [DW-1:0] pd);
    ev_t ev;
    chk({name, " count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      chk({name, " edge"}, ev.edge_n, t0 + nbits * presc + 2);
      chk({name, " dv"}, ev.dv, dv);
      chk({name, " perr"}, ev.pe, pe);
      chk({name, " serr"}, ev.se, se);
      chk({name, " pdata"}, ev.pd, pd);
    end
    evq.delete();
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            presc;
    logic          pen;
    logic          ptyp;
    logic          bad_par;
    logic          stop_val;
    logic          exp_dv;
    logic          exp_pe;
    logic          exp_se;
    logic [DW-1:0] exp_pd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int t0, t1;
    ev_t e1, e2;
    logic [DW-1:0] exp_glitch;

    // reset state
    idle(3);
    chk("reset pdata", P_DATA, 0);
    chk("reset strobes", {DATA_VALID, PAR_ERR, STP_ERR}, 0);
    RST = 1'b1;
    idle(4);
    model_pd = '0;

    // table vectors
    vecs.push_back('{8'h3C, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C});
    vecs.push_back('{8'h5A,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});
    vecs.push_back('{8'hA5, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A});
    vecs.push_back('{8'hA5, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{8'hA5,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{8'h00,  8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5});
    vecs.push_back('{8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5});
    vecs.push_back('{8'h81,  8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5});
    vecs.push_back('{8'h7E, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7E});
    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].data, vecs[i].presc, vecs[i].pen, vecs[i].ptyp, vecs[i].bad_par,
                 vecs[i].stop_val, -1, 1'b1, t0);
      idle(4);
      check_event($sformatf("vec%0d", i), t0, 10 + int'(vecs[i].pen), vecs[i].presc,
                  vecs[i].exp_dv, vecs[i].exp_pe, vecs[i].exp_se, vecs[i].exp_pd);
      chk($sformatf("vec%0d held", i), P_DATA, vecs[i].exp_pd);
    end
    model_pd = 8'h7E;

    // stop error, then a held-low break must not retrigger
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, t0);
    idle(200);
    check_event("break", t0, 10, 8, 1'b0, 1'b0, 1'b1, model_pd);
    RX_IN = 1'b1;
    idle(8);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, t0);
    idle(4);
    check_event("after break", t0, 10, 8, 1'b1, 1'b0, 1'b0, 8'h11);
    model_pd = 8'h11;

    // false start
    PRESCALE = PW'(16);
    RX_IN = 1'b0;
    idle(3);
    RX_IN = 1'b1;
    idle(40);
    chk("false start quiet", evq.size(), 0);
    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, t0);
    idle(4);
    check_event("after false start", t0, 10, 16, 1'b1, 1'b0, 1'b0, 8'hA5);
    model_pd = 8'hA5;

    // back-to-back frames
    send_frame(8'h3C, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1, t0);
    send_frame(8'hC3, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1, t1);
    idle(4);
    chk("b2b count", evq.size(), 2);
    if (evq.size() == 2) begin
      e1 = evq.pop_front();
      e2 = evq.pop_front();
      chk("b2b first edge", e1.edge_n, t0 + 11 * 32 + 2);
      chk("b2b spacing", e2.edge_n - e1.edge_n, 352);
      chk("b2b first data", {e1.dv, e1.pd}, {1'b1, 8'h3C});
      chk("b2b second data", {e2.dv, e2.pd}, {1'b1, 8'hC3});
    end
    evq.delete();

    // reset in the middle of data bit 4 of a third frame
    RX_IN = 1'b0;
    repeat (32 * 5 + 10) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("mid reset pdata", P_DATA, 0);
    chk("mid reset strobes", {DATA_VALID, PAR_ERR, STP_ERR}, 0);
    RX_IN = 1'b1;
    idle(3);
    RST = 1'b1;
    idle(60);
    chk("mid reset quiet", evq.size(), 0);
    evq.delete();
    model_pd = '0;
    send_frame(8'h55, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1, t0);
    idle(4);
    check_event("after reset", t0, 11, 32, 1'b1, 1'b0, 1'b0, 8'h55);
    model_pd = 8'h55;

    // glitch on the mid tick of data bit 2
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'hF0;
`else
    exp_glitch = 8'hF4;
`endif
    send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, t0);
    idle(4);
    check_event("glitch", t0, 10, 8, 1'b1, 1'b0, 1'b0, exp_glitch);
    model_pd = exp_glitch;

    // randomized frames against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] d;
      int presc;
      logic pen, ptyp, bad, stopv, pbit, m_pe, m_dv;
      d     = DW'($urandom);
      presc = 8 << $urandom_range(0, 2);
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      bad   = pen && ($urandom_range(0, 3) == 0);
      stopv = ($urandom_range(0, 3) != 0);
      send_frame(d, presc, pen, ptyp, bad, stopv, -1, 1'b1, t0);
      pbit = par_bit(d, ptyp, bad);
      m_pe = pen && ((($countones(d) + int'(pbit)) % 2) != int'(ptyp));
      m_dv = !m_pe && stopv;
      if (m_dv) model_pd = d;
      idle(4 + $urandom_range(0, 5));
      check_event($sformatf("rand%0d", i), t0, 10 + int'(pen), presc, m_dv, m_pe, !stopv, model_pd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
